// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic tile engine.
// Holds the FSM state encoding, default geometry and the flush length helper.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_SIZE         = 8;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_RESULT_WIDTH = 32;

    // Cycles needed for the last skewed operand to reach the far corner PE.
    function automatic int flush_count(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// Single processing element: forwards a right and x down through registers,
// and accumulates a*x (signed or unsigned) into a wrapping accumulator.
module systolic_pe #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_x,
    output logic [DATA_WIDTH-1:0]   o_a,
    output logic [DATA_WIDTH-1:0]   o_x,
    output logic [RESULT_WIDTH-1:0] o_acc
);

    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_x;
    logic [RESULT_WIDTH-1:0] r_acc;
    logic [RESULT_WIDTH-1:0] w_a_ext;
    logic [RESULT_WIDTH-1:0] w_x_ext;
    logic [RESULT_WIDTH-1:0] w_prod;

    // Extending both operands to full width first makes the truncated product
    // correct modulo 2^RESULT_WIDTH in both signed and unsigned mode.
    assign w_a_ext = {{(RESULT_WIDTH-DATA_WIDTH){i_signed & i_a[DATA_WIDTH-1]}}, i_a};
    assign w_x_ext = {{(RESULT_WIDTH-DATA_WIDTH){i_signed & i_x[DATA_WIDTH-1]}}, i_x};
    assign w_prod  = w_a_ext * w_x_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_x   <= '0;
            r_acc <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= r_acc + w_prod;
            end
            if (i_en) begin
                r_a <= i_a;
                r_x <= i_x;
            end
        end
    end

    assign o_a   = r_a;
    assign o_x   = r_x;
    assign o_acc = r_acc;

endmodule

// File: rtl/systolic_tile_engine.sv
// Output-stationary SIZE x SIZE systolic matrix multiplier with internal input
// skewing, valid/ready operand and result streams, and accumulate-across-tiles.
module systolic_tile_engine
    import systolic_pkg::*;
#(
    parameter int SIZE         = DEF_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           cfg_acc,
    input  logic                           cfg_signed,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [SIZE*DATA_WIDTH-1:0]     a_vec,
    input  logic [SIZE*DATA_WIDTH-1:0]     x_vec,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIZE*RESULT_WIDTH-1:0]   out_row,
    output logic [$clog2(SIZE)-1:0]        out_idx,
    output logic                           busy,
    output logic                           done
);

    localparam int CNT_W = $clog2(2 * SIZE);
    localparam int IDX_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(flush_count(SIZE));
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(SIZE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_signed;
    logic             r_done;
    logic             w_xfer;
    logic             w_en;
    logic             w_clr;
    logic             w_fire;

    logic [DATA_WIDTH-1:0]   w_a_in [SIZE];
    logic [DATA_WIDTH-1:0]   w_x_in [SIZE];
    logic [DATA_WIDTH-1:0]   w_a    [SIZE][SIZE+1];
    logic [DATA_WIDTH-1:0]   w_x    [SIZE+1][SIZE];
    logic [RESULT_WIDTH-1:0] w_acc  [SIZE][SIZE];
    logic [SIZE-1:0]         w_unused_a;
    logic [SIZE-1:0]         w_unused_x;

    assign w_xfer = (r_state == LOAD) && in_valid;
    assign w_en   = (r_state == LOAD) || (r_state == FLUSH);
    assign w_clr  = (r_state == IDLE) && start && !cfg_acc;
    assign w_fire = (r_state == DRAIN) && out_ready;

    // FLUSH ends one cycle after the counter reaches 2*SIZE-1, giving 2*SIZE latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_idx       <= '0;
            r_signed    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_fire && (r_idx == IDX_LAST);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LOAD;
                        r_signed <= cfg_signed;
                    end
                end
                LOAD: begin
                    if (w_xfer && in_last) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state <= DRAIN;
                        r_idx   <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Row/column i sees its operand i cycles late; zeros fill non-transfer cycles.
    for (genvar i = 0; i < SIZE; i++) begin : g_skew
        logic [DATA_WIDTH-1:0] w_a_new;
        logic [DATA_WIDTH-1:0] w_x_new;
        assign w_a_new = w_xfer ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign w_x_new = w_xfer ? x_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        if (i == 0) begin : g_direct
            assign w_a_in[i] = w_a_new;
            assign w_x_in[i] = w_x_new;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] r_a_sr [i];
            logic [DATA_WIDTH-1:0] r_x_sr [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) begin
                        r_a_sr[k] <= '0;
                        r_x_sr[k] <= '0;
                    end
                end else if (w_en) begin
                    r_a_sr[0] <= w_a_new;
                    r_x_sr[0] <= w_x_new;
                    for (int k = 1; k < i; k++) begin
                        r_a_sr[k] <= r_a_sr[k-1];
                        r_x_sr[k] <= r_x_sr[k-1];
                    end
                end
            end
            assign w_a_in[i] = r_a_sr[i-1];
            assign w_x_in[i] = r_x_sr[i-1];
        end
        assign w_a[i][0]     = w_a_in[i];
        assign w_x[0][i]     = w_x_in[i];
        assign w_unused_a[i] = ^w_a[i][SIZE];
        assign w_unused_x[i] = ^w_x[SIZE][i];
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            systolic_pe #(
                .DATA_WIDTH   (DATA_WIDTH),
                .RESULT_WIDTH (RESULT_WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .i_en     (w_en),
                .i_clr    (w_clr),
                .i_signed (r_signed),
                .i_a      (w_a[i][j]),
                .i_x      (w_x[i][j]),
                .o_a      (w_a[i][j+1]),
                .o_x      (w_x[i+1][j]),
                .o_acc    (w_acc[i][j])
            );
        end
    end

    always_comb begin
        out_row = '0;
        if (r_state == DRAIN) begin
            for (int j = 0; j < SIZE; j++) begin
                out_row[j*RESULT_WIDTH +: RESULT_WIDTH] = w_acc[r_idx][j];
            end
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DRAIN);
    assign out_idx   = r_idx;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
